ct_ciu_axi_lpi_ctrl: RTL and testbench

CT_CIU_AXI_LPI_CTRL -- requirements
Module: ct_ciu_axi_lpi_ctrl

---
 rtl/ct_ciu_lpi_pkg.sv | 13 +
 rtl/ct_ciu_lpc_satcnt.sv | 22 ++
 rtl/ct_ciu_axi_lpi_ctrl.sv | 92 +++++++++
 tb/tb_ct_ciu_axi_lpi_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ct_ciu_lpi_pkg.sv
// rtl/ct_ciu_lpi_pkg.sv - shared state encodings and handshake timeout for the AXI low-power interface controller
package ct_ciu_lpi_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      REQ  = 2'b01,
      LP   = 2'b10,
      EXIT = 2'b11
   } lpc_state_e;

   localparam logic [7:0] HS_TIMEOUT = 8'hFF;

endpackage

// File: rtl/ct_ciu_lpc_satcnt.sv
// rtl/ct_ciu_lpc_satcnt.sv - 8-bit saturating counter with clear (priority) and increment, gated by a cycle enable
module ct_ciu_lpc_satcnt (
   input  logic       forever_cpuclk,
   input  logic       cpurst,
   input  logic       cnt_en,
   input  logic       cnt_clr,
   input  logic       cnt_inc,
   output logic [7:0] cnt
);

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         cnt <= 8'd0;
      end else if (cnt_en) begin
         if (cnt_clr)
            cnt <= 8'd0;
         else if (cnt_inc && (cnt != 8'hFF))
            cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/ct_ciu_axi_lpi_ctrl.sv
// rtl/ct_ciu_axi_lpi_ctrl.sv - AXI low-power interface controller: idle qualification, csysreq/csysack handshake,
// clock-stop request, deny pulse and sticky handshake timeout
module ct_ciu_axi_lpi_ctrl
   import ct_ciu_lpi_pkg::*;
(
   input  logic       forever_cpuclk,
   input  logic       cpurst,
   input  logic       clk_en,
   input  logic       lpc_idle_req,
   input  logic       lpc_wake_req,
   input  logic [7:0] lpc_idle_thresh,
   input  logic       ebiu_lpc_csysack,
   input  logic       ebiu_lpc_cactive,
   output logic       lpc_ebiu_csysreq,
   output logic       lpc_clk_stop,
   output logic [1:0] lpc_state,
   output logic       lpc_deny_pulse,
   output logic       lpc_timeout_err
);

   lpc_state_e state, state_nxt;
   logic       csysreq_nxt, clk_stop_nxt, deny_nxt, err_nxt;
   logic       idle_qual, idle_clr;
   logic       hs_inc, hs_clr;
   logic [7:0] idle_cnt, hs_cnt;

   assign idle_qual = lpc_idle_req & ~ebiu_lpc_cactive & ~lpc_wake_req;
   assign idle_clr  = (state != RUN) | ~idle_qual;
   assign hs_inc    = (state == REQ) | (state == EXIT);
   assign hs_clr    = (state_nxt != state);

   ct_ciu_lpc_satcnt u_idle_cnt (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .cnt_en         (clk_en),
      .cnt_clr        (idle_clr),
      .cnt_inc        (idle_qual),
      .cnt            (idle_cnt)
   );

   ct_ciu_lpc_satcnt u_hs_cnt (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .cnt_en         (clk_en),
      .cnt_clr        (hs_clr),
      .cnt_inc        (hs_inc),
      .cnt            (hs_cnt)
   );

   // Only the current state's exit condition is looked at, so csysreq never moves while it differs from csysack.
   always_comb begin
      state_nxt = state;
      deny_nxt  = 1'b0;
      case (state)
         RUN:  if (idle_qual && (idle_cnt >= lpc_idle_thresh)) state_nxt = REQ;
         REQ:  if (!ebiu_lpc_csysack) begin
                  if (ebiu_lpc_cactive) begin
                     state_nxt = EXIT;
                     deny_nxt  = 1'b1;
                  end else begin
                     state_nxt = LP;
                  end
               end
         LP:   if (lpc_wake_req || ebiu_lpc_cactive) state_nxt = EXIT;
         EXIT: if (ebiu_lpc_csysack) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
      csysreq_nxt  = (state_nxt == RUN) || (state_nxt == EXIT);
      clk_stop_nxt = (state_nxt == LP);
      // Flag on the same edge the handshake counter lands on the timeout value.
      err_nxt      = lpc_timeout_err | (hs_inc && !hs_clr && (hs_cnt == HS_TIMEOUT - 8'd1));
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state            <= RUN;
         lpc_ebiu_csysreq <= 1'b1;
         lpc_clk_stop     <= 1'b0;
         lpc_deny_pulse   <= 1'b0;
         lpc_timeout_err  <= 1'b0;
      end else if (clk_en) begin
         state            <= state_nxt;
         lpc_ebiu_csysreq <= csysreq_nxt;
         lpc_clk_stop     <= clk_stop_nxt;
         lpc_deny_pulse   <= deny_nxt;
         lpc_timeout_err  <= err_nxt;
      end
   end

   assign lpc_state = state;

endmodule

// File: tb/tb_ct_ciu_axi_lpi_ctrl.sv
// tb/tb_ct_ciu_axi_lpi_ctrl.sv - directed self-checking bench for the AXI low-power interface controller
module tb_ct_ciu_axi_lpi_ctrl;

   logic       forever_cpuclk;
   logic       cpurst;
   logic       clk_en;
   logic       lpc_idle_req;
   logic       lpc_wake_req;
   logic [7:0] lpc_idle_thresh;
   logic       ebiu_lpc_csysack;
   logic       ebiu_lpc_cactive;
   logic       lpc_ebiu_csysreq;
   logic       lpc_clk_stop;
   logic [1:0] lpc_state;
   logic       lpc_deny_pulse;
   logic       lpc_timeout_err;

   int passed = 0;
   int total  = 0;

   localparam logic [1:0] S_RUN  = 2'b00;
   localparam logic [1:0] S_REQ  = 2'b01;
   localparam logic [1:0] S_LP   = 2'b10;
   localparam logic [1:0] S_EXIT = 2'b11;

   ct_ciu_axi_lpi_ctrl dut (
      .forever_cpuclk   (forever_cpuclk),
      .cpurst           (cpurst),
      .clk_en           (clk_en),
      .lpc_idle_req     (lpc_idle_req),
      .lpc_wake_req     (lpc_wake_req),
      .lpc_idle_thresh  (lpc_idle_thresh),
      .ebiu_lpc_csysack (ebiu_lpc_csysack),
      .ebiu_lpc_cactive (ebiu_lpc_cactive),
      .lpc_ebiu_csysreq (lpc_ebiu_csysreq),
      .lpc_clk_stop     (lpc_clk_stop),
      .lpc_state        (lpc_state),
      .lpc_deny_pulse   (lpc_deny_pulse),
      .lpc_timeout_err  (lpc_timeout_err)
   );

   initial forever_cpuclk = 1'b0;
   always #5 forever_cpuclk = ~forever_cpuclk;

   task automatic tick();
      @(posedge forever_cpuclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // {clk_en, idle_req, wake_req, csysack, expected state}
   logic [5:0] half_rate [10];

   initial begin
      cpurst = 1'b1; clk_en = 1'b1;
      lpc_idle_req = 1'b0; lpc_wake_req = 1'b0; lpc_idle_thresh = 8'd3;
      ebiu_lpc_csysack = 1'b1; ebiu_lpc_cactive = 1'b0;
      tick(); tick();
      cpurst = 1'b0;
      chk("rst_state", {6'd0, lpc_state}, {6'd0, S_RUN});
      chk("rst_csysreq", {7'd0, lpc_ebiu_csysreq}, 8'd1);
      chk("rst_clk_stop", {7'd0, lpc_clk_stop}, 8'd0);
      chk("rst_deny", {7'd0, lpc_deny_pulse}, 8'd0);
      chk("rst_err", {7'd0, lpc_timeout_err}, 8'd0);

      // Entry with thresh=3: csysreq falls on the 4th edge after idle_req rises
      lpc_idle_req = 1'b1;
      tick(); tick(); tick();
      chk("entry_edge3_state", {6'd0, lpc_state}, {6'd0, S_RUN});
      chk("entry_edge3_csysreq", {7'd0, lpc_ebiu_csysreq}, 8'd1);
      tick();
      chk("entry_edge4_state", {6'd0, lpc_state}, {6'd0, S_REQ});
      chk("entry_edge4_csysreq", {7'd0, lpc_ebiu_csysreq}, 8'd0);
      ebiu_lpc_csysack = 1'b0;
      tick();
      chk("accept_state", {6'd0, lpc_state}, {6'd0, S_LP});
      chk("accept_clk_stop", {7'd0, lpc_clk_stop}, 8'd1);

      // Wake from LP
      lpc_wake_req = 1'b1;
      tick();
      lpc_wake_req = 1'b0; lpc_idle_req = 1'b0;
      chk("wake_state", {6'd0, lpc_state}, {6'd0, S_EXIT});
      chk("wake_clk_stop", {7'd0, lpc_clk_stop}, 8'd0);
      chk("wake_csysreq", {7'd0, lpc_ebiu_csysreq}, 8'd1);
      tick();
      chk("exit_wait_ack", {6'd0, lpc_state}, {6'd0, S_EXIT});
      ebiu_lpc_csysack = 1'b1;
      tick();
      chk("exit_to_run", {6'd0, lpc_state}, {6'd0, S_RUN});
      chk("exit_idle_cnt", dut.idle_cnt, 8'd0);

      // thresh=0 entry, wake cannot abort REQ, then deny with a clk_en hold
      lpc_idle_thresh = 8'd0; lpc_idle_req = 1'b1;
      tick();
      chk("thresh0_entry", {6'd0, lpc_state}, {6'd0, S_REQ});
      lpc_wake_req = 1'b1;
      tick();
      lpc_wake_req = 1'b0;
      chk("wake_no_abort_state", {6'd0, lpc_state}, {6'd0, S_REQ});
      chk("wake_no_abort_csysreq", {7'd0, lpc_ebiu_csysreq}, 8'd0);
      ebiu_lpc_csysack = 1'b0; ebiu_lpc_cactive = 1'b1;
      tick();
      chk("deny_state", {6'd0, lpc_state}, {6'd0, S_EXIT});
      chk("deny_pulse", {7'd0, lpc_deny_pulse}, 8'd1);
      chk("deny_csysreq", {7'd0, lpc_ebiu_csysreq}, 8'd1);
      clk_en = 1'b0;
      tick();
      chk("hold_deny_pulse", {7'd0, lpc_deny_pulse}, 8'd1);
      chk("hold_state", {6'd0, lpc_state}, {6'd0, S_EXIT});
      clk_en = 1'b1;
      tick();
      chk("deny_pulse_drop", {7'd0, lpc_deny_pulse}, 8'd0);
      ebiu_lpc_csysack = 1'b1; ebiu_lpc_cactive = 1'b0; lpc_idle_req = 1'b0;
      tick();
      chk("deny_to_run", {6'd0, lpc_state}, {6'd0, S_RUN});

      // Handshake timeout: csysack stuck high in REQ
      lpc_idle_req = 1'b1;
      tick();
      lpc_idle_req = 1'b0;
      chk("to_enter_req", {6'd0, lpc_state}, {6'd0, S_REQ});
      repeat (254) tick();
      chk("to_err_254", {7'd0, lpc_timeout_err}, 8'd0);
      tick();
      chk("to_err_255", {7'd0, lpc_timeout_err}, 8'd1);
      repeat (45) tick();
      chk("to_err_sticky", {7'd0, lpc_timeout_err}, 8'd1);
      chk("to_state_req", {6'd0, lpc_state}, {6'd0, S_REQ});
      chk("to_csysreq", {7'd0, lpc_ebiu_csysreq}, 8'd0);
      ebiu_lpc_csysack = 1'b0;
      tick();
      chk("to_late_accept", {6'd0, lpc_state}, {6'd0, S_LP});

      // Reset from LP overrides clk_en
      cpurst = 1'b1; clk_en = 1'b0;
      tick();
      chk("lp_rst_state", {6'd0, lpc_state}, {6'd0, S_RUN});
      chk("lp_rst_csysreq", {7'd0, lpc_ebiu_csysreq}, 8'd1);
      chk("lp_rst_clk_stop", {7'd0, lpc_clk_stop}, 8'd0);
      chk("lp_rst_err", {7'd0, lpc_timeout_err}, 8'd0);
      cpurst = 1'b0; clk_en = 1'b1; ebiu_lpc_csysack = 1'b1;

      // Full flow with clk_en enabled every other cycle
      lpc_idle_thresh = 8'd1;
      half_rate[0] = {4'b0101, S_RUN};
      half_rate[1] = {4'b1101, S_RUN};
      half_rate[2] = {4'b0101, S_RUN};
      half_rate[3] = {4'b1101, S_REQ};
      half_rate[4] = {4'b0100, S_REQ};
      half_rate[5] = {4'b1100, S_LP};
      half_rate[6] = {4'b0010, S_LP};
      half_rate[7] = {4'b1010, S_EXIT};
      half_rate[8] = {4'b0001, S_EXIT};
      half_rate[9] = {4'b1001, S_RUN};
      for (int i = 0; i < 10; i++) begin
         clk_en           = half_rate[i][5];
         lpc_idle_req     = half_rate[i][4];
         lpc_wake_req     = half_rate[i][3];
         ebiu_lpc_csysack = half_rate[i][2];
         tick();
         chk($sformatf("half_rate_%0d", i), {6'd0, lpc_state}, {6'd0, half_rate[i][1:0]});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
